// File: rtl/prm_edge_chk_engine.sv
`default_nettype none
// ============================================================================
// Module  : prm_edge_chk_engine
// Brief   : Programmable PRM edge checker. It holds a loadable table of
//           sum-of-products terms. Each term drives any subset of N_EDGE edge
//           channels. Occupancy cells stream in per batch, and every batch
//           returns one blocked-edge mask.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           cfg_*            - term table / active term count write port,
//                              accepted only while cfg_ready (IDLE)
//           in_valid/in_ready/in_vec/in_last
//                            - occupancy-cell stream; in_last closes a batch
//           out_valid/out_ready/out_mask/out_cells
//                            - per-batch blocked-edge mask and cell count
// Revision: 1.0 - initial release
// ============================================================================
module prm_edge_chk_engine #(
    parameter int IN_W    = 15,
    parameter int N_EDGE  = 4,
    parameter int N_TERMS = 256,
    parameter int P       = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(N_TERMS)-1:0]   cfg_addr,
    input  logic [IN_W-1:0]              cfg_care,
    input  logic [IN_W-1:0]              cfg_val,
    input  logic [N_EDGE-1:0]            cfg_edge_en,
    input  logic                         cfg_cnt_we,
    input  logic [$clog2(N_TERMS):0]     cfg_cnt,
    output logic                         cfg_ready,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_vec,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_EDGE-1:0]            out_mask,
    output logic [CNT_W-1:0]             out_cells
);

    localparam int c_AW = $clog2(N_TERMS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_OUT  = 2'd2;

    // Term table. It has no reset: entries at or above r_term_cnt are never
    // allowed to contribute, so stale contents are harmless.
    logic [IN_W-1:0]   r_care    [N_TERMS];
    logic [IN_W-1:0]   r_val     [N_TERMS];
    logic [N_EDGE-1:0] r_edge_en [N_TERMS];

    logic [1:0]        r_state;
    logic [c_AW:0]     r_term_cnt;
    logic [c_AW:0]     r_base;
    logic [IN_W-1:0]   r_cell;
    logic              r_last;
    logic [N_EDGE-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [N_EDGE-1:0] r_out_mask;
    logic [CNT_W-1:0]  r_out_cells;

    logic [N_EDGE-1:0] w_lane_hit [P];
    logic [N_EDGE-1:0] w_hit;
    logic [N_EDGE-1:0] w_acc_next;
    logic [c_AW+1:0]   w_base_nxt;
    logic              w_scan_end;
    logic              w_idle;
    logic [c_AW:0]     w_cnt_clamped;

    assign w_idle = (r_state == c_ST_IDLE);

    // ------------------------------------------------------------------
    // Term table write port (IDLE only)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cfg_we && w_idle) begin
            r_care[cfg_addr]    <= cfg_care;
            r_val[cfg_addr]     <= cfg_val;
            r_edge_en[cfg_addr] <= cfg_edge_en;
        end
    end

    // ------------------------------------------------------------------
    // P parallel term-evaluation lanes
    // ------------------------------------------------------------------
    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [c_AW:0]   w_idx;
        logic [c_AW-1:0] w_addr;
        logic            w_act;
        logic            w_match;

        assign w_idx   = r_base + (c_AW+1)'(p);
        assign w_addr  = w_idx[c_AW-1:0];
        assign w_act   = (w_idx < r_term_cnt);
        assign w_match = (((r_cell ^ r_val[w_addr]) & r_care[w_addr]) == '0);
        assign w_lane_hit[p] = (w_act && w_match) ? r_edge_en[w_addr] : '0;
    end

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < P; i++) begin
            w_hit = w_hit | w_lane_hit[i];
        end
    end

    assign w_acc_next = r_acc | w_hit;
    assign w_base_nxt = {1'b0, r_base} + (c_AW+2)'(P);
    // Stop once the window covers every active term. Also stop once all
    // edges are blocked, because later terms can no longer change the mask.
    assign w_scan_end = (w_base_nxt >= {1'b0, r_term_cnt}) || (&w_acc_next);

    // A count above the table depth would wrap the lane index, so it is
    // clamped to the full table.
    assign w_cnt_clamped = (cfg_cnt > (c_AW+1)'(N_TERMS)) ? (c_AW+1)'(N_TERMS) : cfg_cnt;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_term_cnt  <= '0;
            r_base      <= '0;
            r_cell      <= '0;
            r_last      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_out_cells <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_cnt_we) begin
                        r_term_cnt <= w_cnt_clamped;
                    end
                    if (in_valid) begin
                        r_cell  <= in_vec;
                        r_last  <= in_last;
                        r_base  <= '0;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_state <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    r_acc  <= w_acc_next;
                    r_base <= w_base_nxt[c_AW:0];
                    if (w_scan_end) begin
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_out_mask  <= w_acc_next;
                            r_out_cells <= r_cnt;
                            r_state     <= c_ST_OUT;
                        end else begin
                            // Mid-batch cell: keep accumulating across cells.
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_idle;
    assign cfg_ready = w_idle;
    assign out_valid = r_out_valid;
    assign out_mask  = r_out_mask;
    assign out_cells = r_out_cells;

endmodule
`default_nettype wire
